// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one interconnect slave port among four AXI masters,
// with independent write (AW/W/B) and read (AR/R) grant FSMs. Optional macro: ARB_CTRL_PRIO_EN.
module axi_master_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned SEL_W       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] wr_req_i,
    output logic [NUM_MASTERS-1:0] wr_gnt_o,
    output logic [SEL_W-1:0]       wr_sel_o,
    output logic                   wr_busy_o,
    input  logic                   s_awvalid_i,
    input  logic                   s_awready_i,
    input  logic                   s_wvalid_i,
    input  logic                   s_wready_i,
    input  logic                   s_wlast_i,
    input  logic                   s_bvalid_i,
    input  logic                   s_bready_i,
    input  logic [NUM_MASTERS-1:0] rd_req_i,
    output logic [NUM_MASTERS-1:0] rd_gnt_o,
    output logic [SEL_W-1:0]       rd_sel_o,
    output logic                   rd_busy_o,
    input  logic                   s_arvalid_i,
    input  logic                   s_arready_i,
    input  logic                   s_rvalid_i,
    input  logic                   s_rready_i,
    input  logic                   s_rlast_i
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic [SEL_W-1:0]       wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [SEL_W-1:0]       wr_win, rd_win, wr_sel_nxt, rd_sel_nxt;
    logic [NUM_MASTERS-1:0] wr_gnt_nxt, rd_gnt_nxt;
    logic                   wr_ptr_upd, rd_ptr_upd;
    logic                   wlast_seen, wlast_seen_nxt;

    logic aw_hs, wl_hs, b_hs, ar_hs, rl_hs;

    assign aw_hs = s_awvalid_i & s_awready_i;
    assign wl_hs = s_wvalid_i & s_wready_i & s_wlast_i;
    assign b_hs  = s_bvalid_i & s_bready_i;
    assign ar_hs = s_arvalid_i & s_arready_i;
    assign rl_hs = s_rvalid_i & s_rready_i & s_rlast_i;

    // First requester at or after ptr, searching upward with wrap.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic found;
        found   = 1'b0;
        rr_pick = ptr;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % NUM_MASTERS;
            if (!found && req[SEL_W'(idx)]) begin
                rr_pick = SEL_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        next_idx = SEL_W'((32'(idx) + 32'd1) % NUM_MASTERS);
    endfunction

    // Winner selection; the controller may override round-robin.
    always_comb begin
        wr_win     = rr_pick(wr_req_i, wr_ptr);
        rd_win     = rr_pick(rd_req_i, rd_ptr);
        wr_ptr_upd = 1'b1;
        rd_ptr_upd = 1'b1;
`ifdef ARB_CTRL_PRIO_EN
        if (wr_req_i[0]) begin
            wr_win     = '0;
            wr_ptr_upd = 1'b0;
        end
        if (rd_req_i[0]) begin
            rd_win     = '0;
            rd_ptr_upd = 1'b0;
        end
`endif
    end

    always_comb begin
        wr_state_nxt   = wr_state;
        wr_gnt_nxt     = wr_gnt_o;
        wr_sel_nxt     = wr_sel_o;
        wr_ptr_nxt     = wr_ptr;
        wlast_seen_nxt = wlast_seen;
        case (wr_state)
            W_IDLE: begin
                if (|wr_req_i) begin
                    wr_state_nxt       = W_ADDR;
                    wr_gnt_nxt         = '0;
                    wr_gnt_nxt[wr_win] = 1'b1;
                    wr_sel_nxt         = wr_win;
                    if (wr_ptr_upd) wr_ptr_nxt = next_idx(wr_win);
                end
            end
            W_ADDR: begin
                if (wl_hs) wlast_seen_nxt = 1'b1;
                if (aw_hs) wr_state_nxt = (wlast_seen || wl_hs) ? W_RESP : W_DATA;
            end
            W_DATA: begin
                if (wl_hs) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_state_nxt   = W_IDLE;
                    wr_gnt_nxt     = '0;
                    wlast_seen_nxt = 1'b0;
                end
            end
            default: begin
                wr_state_nxt   = W_IDLE;
                wr_gnt_nxt     = '0;
                wlast_seen_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_gnt_nxt   = rd_gnt_o;
        rd_sel_nxt   = rd_sel_o;
        rd_ptr_nxt   = rd_ptr;
        case (rd_state)
            R_IDLE: begin
                if (|rd_req_i) begin
                    rd_state_nxt       = R_ADDR;
                    rd_gnt_nxt         = '0;
                    rd_gnt_nxt[rd_win] = 1'b1;
                    rd_sel_nxt         = rd_win;
                    if (rd_ptr_upd) rd_ptr_nxt = next_idx(rd_win);
                end
            end
            R_ADDR: begin
                if (ar_hs) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                if (rl_hs) begin
                    rd_state_nxt = R_IDLE;
                    rd_gnt_nxt   = '0;
                end
            end
            default: begin
                rd_state_nxt = R_IDLE;
                rd_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state   <= W_IDLE;
            wr_gnt_o   <= '0;
            wr_sel_o   <= '0;
            wr_busy_o  <= 1'b0;
            wr_ptr     <= '0;
            wlast_seen <= 1'b0;
            rd_state   <= R_IDLE;
            rd_gnt_o   <= '0;
            rd_sel_o   <= '0;
            rd_busy_o  <= 1'b0;
            rd_ptr     <= '0;
        end else begin
            wr_state   <= wr_state_nxt;
            wr_gnt_o   <= wr_gnt_nxt;
            wr_sel_o   <= wr_sel_nxt;
            wr_busy_o  <= (wr_state_nxt != W_IDLE);
            wr_ptr     <= wr_ptr_nxt;
            wlast_seen <= wlast_seen_nxt;
            rd_state   <= rd_state_nxt;
            rd_gnt_o   <= rd_gnt_nxt;
            rd_sel_o   <= rd_sel_nxt;
            rd_busy_o  <= (rd_state_nxt != R_IDLE);
            rd_ptr     <= rd_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: rotation, burst hold, early wlast,
// independent paths and mid-burst reset. Expectations follow ARB_CTRL_PRIO_EN.
module tb_axi_master_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  wr_req, wr_gnt, rd_req, rd_gnt;
    logic [SW-1:0] wr_sel, rd_sel;
    logic          wr_busy, rd_busy;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;

    int tests  = 0;
    int failed = 0;

    axi_master_arbiter #(.NUM_MASTERS(N), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset),
        .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_sel_o(wr_sel), .wr_busy_o(wr_busy),
        .s_awvalid_i(awvalid), .s_awready_i(awready),
        .s_wvalid_i(wvalid), .s_wready_i(wready), .s_wlast_i(wlast),
        .s_bvalid_i(bvalid), .s_bready_i(bready),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_sel_o(rd_sel), .rd_busy_o(rd_busy),
        .s_arvalid_i(arvalid), .s_arready_i(arready),
        .s_rvalid_i(rvalid), .s_rready_i(rready), .s_rlast_i(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hs();
        {awvalid, awready, wvalid, wready, wlast, bvalid, bready} = '0;
        {arvalid, arready, rvalid, rready, rlast} = '0;
    endtask

    task automatic aw_hs();  awvalid = 1'b1; awready = 1'b1; endtask
    task automatic wl_hs();  wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; endtask
    task automatic b_hs();   bvalid = 1'b1; bready = 1'b1; endtask
    task automatic ar_hs();  arvalid = 1'b1; arready = 1'b1; endtask
    task automatic r_beat(input logic last); rvalid = 1'b1; rready = 1'b1; rlast = last; endtask

    int unsigned exp_wr_seq [5];
    logic [N-1:0] oh;

    initial begin
`ifdef ARB_CTRL_PRIO_EN
        exp_wr_seq = '{0, 0, 0, 0, 0};
`else
        exp_wr_seq = '{0, 1, 2, 3, 0};
`endif
        reset  = 1'b1;
        wr_req = '0;
        rd_req = '0;
        clear_hs();
        step();
        step();
        chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        chk("rst_wr_sel", 32'(wr_sel), 32'h0);
        chk("rst_wr_busy", 32'(wr_busy), 32'h0);
        chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        chk("rst_rd_sel", 32'(rd_sel), 32'h0);
        chk("rst_rd_busy", 32'(rd_busy), 32'h0);
        reset = 1'b0;

        // Write rotation with all masters requesting
        wr_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            oh = '0;
            oh[exp_wr_seq[k]] = 1'b1;
            chk($sformatf("rot%0d_gnt", k), 32'(wr_gnt), 32'(oh));
            chk($sformatf("rot%0d_sel", k), 32'(wr_sel), exp_wr_seq[k]);
            chk($sformatf("rot%0d_busy", k), 32'(wr_busy), 32'h1);
            aw_hs(); step(); clear_hs();
            chk($sformatf("rot%0d_hold_aw", k), 32'(wr_gnt), 32'(oh));
            wl_hs(); step(); clear_hs();
            chk($sformatf("rot%0d_hold_w", k), 32'(wr_gnt), 32'(oh));
            b_hs(); step(); clear_hs();
            chk($sformatf("rot%0d_rel_gnt", k), 32'(wr_gnt), 32'h0);
            chk($sformatf("rot%0d_rel_busy", k), 32'(wr_busy), 32'h0);
            if (k == 4) wr_req = '0;
        end
        step();
        chk("wr_dropped_req", 32'(wr_gnt), 32'h0);

        // Read round-robin 1 then 3, 4-beat burst hold
        rd_req = 4'b1010;
        step();
        chk("rd1_gnt", 32'(rd_gnt), 32'h2);
        chk("rd1_sel", 32'(rd_sel), 32'h1);
        chk("rd1_busy", 32'(rd_busy), 32'h1);
        rd_req = 4'b0100;
        ar_hs(); step(); clear_hs();
        chk("rd1_hold_ar", 32'(rd_gnt), 32'h2);
        rd_req = 4'b1010;
        for (int b = 0; b < 4; b++) begin
            r_beat(b == 3); step(); clear_hs();
            if (b < 3) chk($sformatf("rd1_beat%0d_hold", b), 32'(rd_gnt), 32'h2);
        end
        chk("rd1_rel_gnt", 32'(rd_gnt), 32'h0);
        chk("rd1_rel_busy", 32'(rd_busy), 32'h0);
        step();
        chk("rd2_gnt", 32'(rd_gnt), 32'h8);
        chk("rd2_sel", 32'(rd_sel), 32'h3);
        rd_req = '0;
        ar_hs(); step(); clear_hs();
        r_beat(1'b1); step(); clear_hs();
        chk("rd2_rel_gnt", 32'(rd_gnt), 32'h0);

        // Wlast before AW: W_ADDR goes straight to W_RESP; B ignored before that
        wr_req = 4'b0100;
        step();
        chk("ew_sel", 32'(wr_sel), 32'h2);
        chk("ew_gnt", 32'(wr_gnt), 32'h4);
        wr_req = '0;
        wl_hs(); step(); clear_hs();
        chk("ew_hold_w", 32'(wr_gnt), 32'h4);
        b_hs(); step(); clear_hs();
        chk("ew_b_ignored", 32'(wr_gnt), 32'h4);
        aw_hs(); step(); clear_hs();
        chk("ew_hold_aw", 32'(wr_busy), 32'h1);
        b_hs(); step(); clear_hs();
        chk("ew_rel_gnt", 32'(wr_gnt), 32'h0);
        chk("ew_rel_busy", 32'(wr_busy), 32'h0);

        // Simultaneous AW and wlast
        wr_req = 4'b0100;
        step();
        wr_req = '0;
        aw_hs(); wl_hs(); step(); clear_hs();
        chk("sim_hold", 32'(wr_gnt), 32'h4);
        b_hs(); step(); clear_hs();
        chk("sim_rel_gnt", 32'(wr_gnt), 32'h0);

        // Master 2 holds both paths, which complete independently
        wr_req = 4'b0100;
        rd_req = 4'b0100;
        step();
        chk("both_wr_gnt", 32'(wr_gnt), 32'h4);
        chk("both_rd_gnt", 32'(rd_gnt), 32'h4);
        chk("both_wr_busy", 32'(wr_busy), 32'h1);
        chk("both_rd_busy", 32'(rd_busy), 32'h1);
        wr_req = '0;
        rd_req = '0;
        aw_hs(); step(); clear_hs();
        b_hs(); step(); clear_hs();
        chk("both_wdata_b_ignored", 32'(wr_busy), 32'h1);
        ar_hs(); step(); clear_hs();
        r_beat(1'b1); step(); clear_hs();
        chk("both_rd_rel_gnt", 32'(rd_gnt), 32'h0);
        chk("both_rd_rel_busy", 32'(rd_busy), 32'h0);
        chk("both_wr_still", 32'(wr_gnt), 32'h4);
        wl_hs(); step(); clear_hs();
        chk("both_wresp_busy", 32'(wr_busy), 32'h1);
        b_hs(); step(); clear_hs();
        chk("both_wr_rel_gnt", 32'(wr_gnt), 32'h0);
        chk("both_wr_rel_busy", 32'(wr_busy), 32'h0);

        // Reset mid R_DATA clears grant and pointer
        rd_req = 4'b0010;
        step();
        chk("rr_sel", 32'(rd_sel), 32'h1);
        rd_req = '0;
        ar_hs(); step(); clear_hs();
        r_beat(1'b0); step(); clear_hs();
        chk("rr_hold", 32'(rd_gnt), 32'h2);
        reset = 1'b1;
        step();
        chk("rr_rst_gnt", 32'(rd_gnt), 32'h0);
        chk("rr_rst_busy", 32'(rd_busy), 32'h0);
        chk("rr_rst_sel", 32'(rd_sel), 32'h0);
        reset  = 1'b0;
        rd_req = 4'b1001;
        step();
        chk("rr_ptr_reset_sel", 32'(rd_sel), 32'h0);
        rd_req = '0;
        ar_hs(); step(); clear_hs();
        r_beat(1'b1); step(); clear_hs();
        chk("rr_done_gnt", 32'(rd_gnt), 32'h0);
        rd_req = 4'b1000;
        step();
        chk("rr_m3_sel", 32'(rd_sel), 32'h3);
        chk("rr_m3_gnt", 32'(rd_gnt), 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
